merge_stream_controller: RTL and testbench
==========================================

Name: merge_stream_controller

Overview:
- Sequences the raster pixel stream feeding the paddle-localization window/merge datapath.
- Tracks frame position and gates line-buffer shifting. Delays the 1-bit edge stream so each edge bit arrives together with its M_SIZE x M_SIZE color window.
- Emits window-valid, border and center-coordinate qualifiers, plus an end-of-frame pulse.
- Sits between the camera/edge front end and the edge/color mask merge stage.

Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- M_SIZE, 11, window side (odd); CENTER = M_SIZE/2
- Derived DELAY = CENTER*IMG_W + CENTER, edge alignment depth in pixels
- Derived XW = $clog2(IMG_W), YW = $clog2(IMG_H)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input pixel present
- in_sof  in  1  first pixel of frame; qualified by in_valid
- in_edge  in  1  edge bit of input pixel
- in_ready  out  1  controller accepts pixel this cycle
- lb_shift  out  1  shift enable to line buffers/window registers
- lb_flush  out  1  during FLUSH, line buffers shift in zero/invalid pixels
- out_valid  out  1  aligned window + edge available
- out_edge  out  1  edge bit aligned to window center
- out_border  out  1  window center within CENTER of any image edge
- out_x  out  XW  center column
- out_y  out  YW  center row
- frame_done  out  1  one-cycle pulse with last out_valid of frame

Behaviour:
- Reset (async) values: state=IDLE; all outputs 0 except in_ready=1; pointers and counters 0.
- Accept = in_valid & in_ready. lb_shift = accept in FILL/RUN, or 1 in FLUSH (combinational).
- Edge delay: circular 1-bit buffer of DELAY entries.
  - Write pointer advances on every accept.
  - Read pointer advances once the buffer holds DELAY entries.
  - Both pointers wrap at DELAY-1 -> 0.
  - Read data feeds out_edge.
- States:
  - IDLE: in_ready=1. Pixels without in_sof are accepted and dropped (no lb_shift). Accept with in_sof -> FILL; that pixel is written as index 0.
  - FILL: count accepted pixels in in_cnt. When in_cnt reaches DELAY (i.e. DELAY+1 pixels accepted) -> RUN. That last accept produces the first out_valid on the next cycle.
  - RUN: each accept produces one out_valid on the next clock (registered, latency 1 cycle from accept). When in_cnt reaches IMG_W*IMG_H-1 on an accept -> FLUSH.
  - FLUSH: in_ready=0, lb_flush=1. One out_valid per cycle for DELAY cycles, drawing the remaining buffered edge bits. After the last one -> IDLE.
- Output coordinates:
  - out_x/out_y count emitted pixels in raster order. Start 0,0 at the first out_valid of a frame.
  - out_x wraps IMG_W-1 -> 0 with out_y+1.
  - Exactly IMG_W*IMG_H out_valid pulses per complete frame.
- out_border = (out_x < CENTER) | (out_x >= IMG_W-CENTER) | (out_y < CENTER) | (out_y >= IMG_H-CENTER). out_edge is passed through unmasked; the merge stage gates it using out_border.
- frame_done is asserted in the same cycle as out_valid with out_x=IMG_W-1, out_y=IMG_H-1.
- in_sof accepted in FILL or RUN:
  - abort the current frame; no frame_done;
  - reset pointers and counters;
  - the sof pixel becomes index 0 and state goes to FILL.
  - out_valid for the aborted frame stops immediately.
- in_sof while in FLUSH is not accepted (in_ready=0). The source holds it; it is taken in IDLE.
- in_valid low in FILL/RUN: no shift, no output, counters hold. Gaps are allowed anywhere.
- Reset asserted mid-frame: all state cleared asynchronously. No frame_done.

Test Plan (IMG_W=16, IMG_H=12, M_SIZE=3 -> CENTER=1, DELAY=17):
- Continuous frame of 192 pixels, in_edge=1 only at pixel index 40 -> first out_valid the cycle after the 18th accept; out_edge=1 exactly at out_x=8, out_y=2; 192 out_valid total; FLUSH lasts 17 cycles with in_ready=0; frame_done with x=15, y=11.
- Same frame with in_valid randomly low 50% -> identical out_edge/out_x/out_y sequence; out_valid count 192.
- Border flags -> out_border=1 for x in {0,15} or y in {0,11}; 0 for (1,1) through (14,10); 140 non-border pixels.
- Second in_sof at input pixel 100 of frame -> no frame_done; counters restart; the next complete frame emits 192 out_valid and one frame_done.
- Pixels without in_sof in IDLE (5 pixels) -> no lb_shift, no out_valid; the following sof frame behaves as in scenario 1.
- Reset pulse at out pixel 50 -> all outputs 0 and in_ready=1 within the same cycle; the next frame is correct.

Source files
------------

// File: rtl/merge_stream_controller_if.sv
// Stream bundle between the camera/edge front end, the controller and the
// merge stage: pixel handshake in, line-buffer control and qualifiers out.
interface merge_stream_controller_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic          in_valid;
    logic          in_sof;
    logic          in_edge;
    logic          in_ready;
    logic          lb_shift;
    logic          lb_flush;
    logic          out_valid;
    logic          out_edge;
    logic          out_border;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          frame_done;

    // Pixel source / result consumer side
    modport master (
        output in_valid, in_sof, in_edge,
        input  in_ready, lb_shift, lb_flush, out_valid, out_edge,
        input  out_border, out_x, out_y, frame_done
    );

    // Controller side
    modport slave (
        input  in_valid, in_sof, in_edge,
        output in_ready, lb_shift, lb_flush, out_valid, out_edge,
        output out_border, out_x, out_y, frame_done
    );
endinterface

// File: rtl/merge_stream_controller.sv
// Raster sequencer for the paddle-localization window/merge datapath.
// Gates line-buffer shifting, delays the edge bit so it lines up with the
// centre of its window, and produces centre coordinates, border flag and an
// end-of-frame pulse.
module merge_stream_controller #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int M_SIZE = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    merge_stream_controller_if.slave bus
);
    localparam int CENTER = M_SIZE / 2;
    localparam int DELAY  = CENTER * IMG_W + CENTER;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int PW     = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int CW     = $clog2(NPIX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q;
    logic [DELAY-1:0] ebuf_q;        // circular edge delay line
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [PW-1:0]   fcnt_q;         // flush cycles already issued
    logic [CW-1:0]   in_cnt_q;       // raster index of the next accepted pixel
    logic [XW-1:0]   nx_q;           // coordinate the next emitted pixel gets
    logic [YW-1:0]   ny_q;

    logic            in_ready_q;
    logic            lb_flush_q;
    logic            out_valid_q;
    logic            out_edge_q;
    logic            out_border_q;
    logic [XW-1:0]   out_x_q;
    logic [YW-1:0]   out_y_q;
    logic            frame_done_q;

    logic            accept_d;
    logic            emit_d;
    logic            rd_bit_d;
    logic            last_pix_d;

    // Advance a delay-line pointer, wrapping after the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DELAY - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // A window centre is a border pixel when its window would hang off the image.
    function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (int'(x) < CENTER) || (int'(x) >= IMG_W - CENTER) ||
               (int'(y) < CENTER) || (int'(y) >= IMG_H - CENTER);
    endfunction

    assign accept_d   = bus.in_valid & in_ready_q;
    assign rd_bit_d   = ebuf_q[rptr_q];
    assign last_pix_d = (nx_q == XW'(IMG_W - 1)) && (ny_q == YW'(IMG_H - 1));

    // One window centre leaves per flush cycle, or per non-sof accept once the
    // delay line is primed (the accept of raster index DELAY is the first).
    assign emit_d = (state_q == S_FLUSH) |
                    (accept_d & ~bus.in_sof &
                     ((state_q == S_RUN) |
                      ((state_q == S_FILL) & (in_cnt_q == CW'(DELAY)))));

    // The sof pixel is raster index 0 of the window, so it shifts in as well;
    // non-sof pixels seen while idle are discarded without shifting.
    assign bus.lb_shift = (state_q == S_FLUSH) |
                          (accept_d & ((state_q == S_FILL) | (state_q == S_RUN) | bus.in_sof));

    assign bus.in_ready   = in_ready_q;
    assign bus.lb_flush   = lb_flush_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_edge   = out_edge_q;
    assign bus.out_border = out_border_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.frame_done = frame_done_q;

    // Frame sequencer: state, delay line, counters and registered qualifiers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ebuf_q       <= {DELAY{1'b0}};
            wptr_q       <= {PW{1'b0}};
            rptr_q       <= {PW{1'b0}};
            fcnt_q       <= {PW{1'b0}};
            in_cnt_q     <= {CW{1'b0}};
            nx_q         <= {XW{1'b0}};
            ny_q         <= {YW{1'b0}};
            in_ready_q   <= 1'b1;
            lb_flush_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_edge_q   <= 1'b0;
            out_border_q <= 1'b0;
            out_x_q      <= {XW{1'b0}};
            out_y_q      <= {YW{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;

            // The read happens before the same-cycle write lands, so a full
            // ring of DELAY entries hands out the oldest bit as it is replaced.
            if (emit_d) begin
                out_valid_q  <= 1'b1;
                out_edge_q   <= rd_bit_d;
                out_x_q      <= nx_q;
                out_y_q      <= ny_q;
                out_border_q <= is_border(nx_q, ny_q);
                frame_done_q <= last_pix_d;
                rptr_q       <= ptr_inc(rptr_q);
                if (nx_q == XW'(IMG_W - 1)) begin
                    nx_q <= {XW{1'b0}};
                    ny_q <= ny_q + YW'(1);
                end else begin
                    nx_q <= nx_q + XW'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_d && bus.in_sof) begin
                        ebuf_q[0] <= bus.in_edge;
                        wptr_q    <= ptr_inc({PW{1'b0}});
                        rptr_q    <= {PW{1'b0}};
                        in_cnt_q  <= CW'(1);
                        nx_q      <= {XW{1'b0}};
                        ny_q      <= {YW{1'b0}};
                        state_q   <= S_FILL;
                    end
                end
                S_FILL, S_RUN: begin
                    if (accept_d) begin
                        if (bus.in_sof) begin
                            // Abort: the sof pixel restarts the frame as index 0.
                            ebuf_q[0] <= bus.in_edge;
                            wptr_q    <= ptr_inc({PW{1'b0}});
                            rptr_q    <= {PW{1'b0}};
                            in_cnt_q  <= CW'(1);
                            nx_q      <= {XW{1'b0}};
                            ny_q      <= {YW{1'b0}};
                            state_q   <= S_FILL;
                        end else begin
                            ebuf_q[wptr_q] <= bus.in_edge;
                            wptr_q         <= ptr_inc(wptr_q);
                            in_cnt_q       <= in_cnt_q + CW'(1);
                            if ((state_q == S_FILL) && (in_cnt_q == CW'(DELAY))) begin
                                state_q <= S_RUN;
                            end else if ((state_q == S_RUN) && (in_cnt_q == CW'(NPIX - 1))) begin
                                state_q    <= S_FLUSH;
                                in_ready_q <= 1'b0;
                                lb_flush_q <= 1'b1;
                                fcnt_q     <= {PW{1'b0}};
                            end else begin
                                state_q <= state_q;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    fcnt_q <= fcnt_q + PW'(1);
                    if (fcnt_q == PW'(DELAY - 1)) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        lb_flush_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    lb_flush_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_merge_stream_controller.sv
// Directed/randomized bench for merge_stream_controller at a small image
// size. A raster-level reference model predicts every sampled output.
module tb_merge_stream_controller;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 12;
    localparam int M_SIZE = 3;
    localparam int CENTER = M_SIZE / 2;
    localparam int DELAY  = CENTER * IMG_W + CENTER;
    localparam int NPIX   = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst;

    merge_stream_controller_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) ifc ();

    merge_stream_controller #(.IMG_W(IMG_W), .IMG_H(IMG_H), .M_SIZE(M_SIZE)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model state (raster-level)
    bit   frame_active = 1'b0;
    int   idx = 0;            // raster index of next input pixel
    int   out_k = 0;          // raster index of next output pixel
    int   flush_rem = 0;      // flush emissions still to come
    logic fedge [0:NPIX-1];
    logic exp_valid = 1'b0, exp_edge = 1'b0, exp_border = 1'b0, exp_done = 1'b0;
    int   exp_x = 0, exp_y = 0;

    // observed per-frame statistics
    int obs_valid, obs_done, obs_nb, edge_hits, edge_x, edge_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic emit();
        exp_valid  = 1'b1;
        exp_edge   = fedge[out_k];
        exp_x      = out_k % IMG_W;
        exp_y      = out_k / IMG_W;
        exp_border = (exp_x < CENTER) || (exp_x >= IMG_W - CENTER) ||
                     (exp_y < CENTER) || (exp_y >= IMG_H - CENTER);
        exp_done   = (out_k == NPIX - 1);
        out_k++;
    endtask

    // predict what the coming clock edge produces
    task automatic model_update(input logic s, input logic e, input logic acc);
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (flush_rem > 0) begin
            emit();
            flush_rem--;
        end else if (acc) begin
            if (s) begin
                frame_active = 1'b1;
                fedge[0] = e;
                idx = 1;
                out_k = 0;
            end else if (frame_active) begin
                fedge[idx] = e;
                if (idx >= DELAY) emit();
                if (idx == NPIX - 1) begin
                    frame_active = 1'b0;
                    flush_rem = DELAY;
                end
                idx++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", ifc.out_valid, exp_valid);
        chk("in_ready", ifc.in_ready, (flush_rem == 0));
        chk("lb_flush", ifc.lb_flush, (flush_rem > 0));
        chk("frame_done", ifc.frame_done, exp_done);
        if (exp_valid && ifc.out_valid) begin
            chk("out_edge", ifc.out_edge, exp_edge);
            chk("out_x", ifc.out_x, exp_x);
            chk("out_y", ifc.out_y, exp_y);
            chk("out_border", ifc.out_border, exp_border);
        end
        if (ifc.out_valid) begin
            obs_valid++;
            if (!ifc.out_border) obs_nb++;
            if (ifc.out_edge) begin
                edge_hits++;
                edge_x = ifc.out_x;
                edge_y = ifc.out_y;
            end
        end
        if (ifc.frame_done) obs_done++;
    endtask

    // one clock: check previous edge's results, drive, predict, advance
    task automatic step(input logic v, input logic s, input logic e, output logic acc);
        logic exp_sh;
        bit   sh_chk;
        check_outputs();
        ifc.in_valid = v;
        ifc.in_sof   = s;
        ifc.in_edge  = e;
        acc    = v && (flush_rem == 0);
        exp_sh = (flush_rem > 0) || (acc && frame_active);
        sh_chk = !(acc && s && !frame_active);
        #1;
        if (sh_chk) chk("lb_shift", ifc.lb_shift, exp_sh);
        model_update(s, e, acc);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_lb_shift", ifc.lb_shift, 0);
        chk("rst_lb_flush", ifc.lb_flush, 0);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_edge", ifc.out_edge, 0);
        chk("rst_out_border", ifc.out_border, 0);
        chk("rst_out_x", ifc.out_x, 0);
        chk("rst_out_y", ifc.out_y, 0);
        chk("rst_frame_done", ifc.frame_done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_sof   = 1'b0;
        #1;
        check_reset_outputs();
        frame_active = 1'b0;
        flush_rem = 0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, a);
    endtask

    // mode 0: edge only at pixel 40; mode 1: random edges
    task automatic send_frame(input int mode, input int gap, input int stop_at, input int rst_at);
        logic a, e;
        int   guard;
        obs_valid = 0; obs_done = 0; obs_nb = 0;
        edge_hits = 0; edge_x = -1; edge_y = -1;
        for (int p = 0; p < NPIX; p++) begin
            if (p == stop_at) return;
            e = (mode == 0) ? (p == 40) : logic'($urandom_range(0, 1));
            a = 1'b0;
            guard = 0;
            while (!a) begin
                if (rst_at >= 0 && out_k >= rst_at && frame_active) begin
                    do_reset();
                    return;
                end
                if (guard > 200) begin
                    chk("accept_timeout", 0, 1);
                    return;
                end
                if (gap > 0 && $urandom_range(0, 99) < gap)
                    step(1'b0, 1'b0, 1'b0, a);
                else
                    step(1'b1, (p == 0), e, a);
                guard++;
            end
        end
    endtask

    task automatic full_frame_checks(input bit edge40);
        chk("frame_valid_count", obs_valid, NPIX);
        chk("frame_done_count", obs_done, 1);
        chk("frame_nonborder", obs_nb, (IMG_W - 2 * CENTER) * (IMG_H - 2 * CENTER));
        if (edge40) begin
            chk("edge_hits", edge_hits, 1);
            chk("edge_x", edge_x, 8);
            chk("edge_y", edge_y, 2);
        end
    endtask

    initial begin
        logic a;
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_sof   = 1'b0;
        ifc.in_edge  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // continuous frame, single edge at pixel 40
        send_frame(0, 0, -1, -1);
        idle(DELAY + 2);
        full_frame_checks(1'b1);

        // same frame with ~50% input gaps
        send_frame(0, 50, -1, -1);
        idle(DELAY + 2);
        full_frame_checks(1'b1);

        // random edges, light gaps
        send_frame(1, 20, -1, -1);
        idle(DELAY + 2);
        full_frame_checks(1'b0);

        // abort at input pixel 100, then a complete frame
        send_frame(1, 0, 100, -1);
        idle(1);
        chk("abort_valid_count", obs_valid, 100 - DELAY);
        chk("abort_frame_done", obs_done, 0);
        send_frame(1, 0, -1, -1);
        idle(DELAY + 2);
        full_frame_checks(1'b0);

        // stray pixels while idle are dropped
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, logic'($urandom_range(0, 1)), a);
        idle(2);
        send_frame(0, 0, -1, -1);
        idle(DELAY + 2);
        full_frame_checks(1'b1);

        // reset mid-frame at output pixel 50, then a clean frame
        send_frame(1, 0, -1, 50);
        idle(2);
        chk("reset_frame_done", obs_done, 0);
        send_frame(0, 30, -1, -1);
        idle(DELAY + 2);
        full_frame_checks(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
